mips_multicycle_ctrl: RTL and testbench

MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

---
 rtl/mips_multicycle_ctrl.sv | 169 ++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: Moore state decode plus PC write enable.
// Define MIPS_CTRL_BNE_EN to route bne through the branch state.
module mips_multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic [3:0] aluop,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0110;
  localparam logic [3:0] ALU_NOR = 4'b0111;
  localparam logic [3:0] ALU_SLT = 4'b1010;

  state_t     cur;
  state_t     nxt;
  logic       pcwrite;
  logic       branch;
  logic       is_bne;
  logic       funct_ok;
  logic [3:0] rtype_alu;

`ifdef MIPS_CTRL_BNE_EN
  assign is_bne = (op == OP_BNE);
`else
  assign is_bne = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) cur <= FETCH;
    else       cur <= nxt;
  end

  always_comb begin
    funct_ok  = 1'b1;
    rtype_alu = ALU_ADD;
    case (funct)
      6'b100000: rtype_alu = ALU_ADD;
      6'b100010: rtype_alu = ALU_SUB;
      6'b100100: rtype_alu = ALU_AND;
      6'b100101: rtype_alu = ALU_OR;
      6'b100110: rtype_alu = ALU_XOR;
      6'b100111: rtype_alu = ALU_NOR;
      6'b101010: rtype_alu = ALU_SLT;
      default:   funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    nxt = FETCH;
    case (cur)
      FETCH:   nxt = DECODE;
      DECODE: begin
        if (op == OP_LW || op == OP_SW) nxt = MEMADR;
        else if (op == OP_RTYP)         nxt = RTYPEEX;
        else if (op == OP_BEQ)          nxt = BEQEX;
        else if (is_bne)                nxt = BEQEX;
        else if (op == OP_ADDI)         nxt = ADDIEX;
        else if (op == OP_J)            nxt = JEX;
        else                            nxt = FETCH;
      end
      MEMADR:  nxt = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   nxt = MEMWB;
      // illegal funct aborts before writeback
      RTYPEEX: nxt = funct_ok ? RTYPEWB : FETCH;
      ADDIEX:  nxt = ADDIWB;
      default: nxt = FETCH;
    endcase
  end

  always_comb begin
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    aluop    = ALU_ADD;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    case (cur)
      FETCH: begin
        alusrcb = 2'b01;
        irwrite = 1'b1;
        pcwrite = 1'b1;
      end
      DECODE:  alusrcb = 2'b11;
      MEMADR, ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD:   iord = 1'b1;
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = rtype_alu;
      end
      RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BEQEX: begin
        alusrca = 1'b1;
        aluop   = ALU_SUB;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      ADDIWB:  regwrite = 1'b1;
      JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign pcen  = pcwrite | (branch & (is_bne ? ~zero : zero));
  assign state = cur;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: path-table model checked every cycle
// plus literal latency/sequence checks.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite;
  logic       alusrca, pcen;
  logic [1:0] alusrcb, pcsrc;
  logic [3:0] aluop, state;

  int checks = 0;
  int errors = 0;

  mips_multicycle_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .pcen(pcen), .aluop(aluop), .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] funct_alu(input logic [5:0] f,
                                           output logic ok);
    ok = 1'b1;
    case (f)
      6'b100000: return 4'b0000;
      6'b100010: return 4'b0010;
      6'b100100: return 4'b0100;
      6'b100101: return 4'b0101;
      6'b100110: return 4'b0110;
      6'b100111: return 4'b0111;
      6'b101010: return 4'b1010;
      default: begin
        ok = 1'b0;
        return 4'b0000;
      end
    endcase
  endfunction

  // States visited after FETCH, one nibble each, first at [3:0]
  function automatic logic [31:0] path_of(input logic [5:0] o,
                                          input logic [5:0] f,
                                          output int n);
    logic ok;
    logic [3:0] unused_alu;
    case (o)
      6'b100011: begin n = 4; return 32'h0000_4321; end
      6'b101011: begin n = 3; return 32'h0000_0521; end
      6'b000000: begin
        unused_alu = funct_alu(f, ok);
        if (ok) begin n = 3; return 32'h0000_0761; end
        n = 2;
        return 32'h0000_0061;
      end
      6'b000100: begin n = 2; return 32'h0000_0081; end
`ifdef MIPS_CTRL_BNE_EN
      6'b000101: begin n = 2; return 32'h0000_0081; end
`endif
      6'b001000: begin n = 3; return 32'h0000_0A91; end
      6'b000010: begin n = 2; return 32'h0000_0B1; end
      default:   begin n = 1; return 32'h0000_0001; end
    endcase
  endfunction

  function automatic logic [19:0] exp_vec(input logic [3:0] s,
                                          input logic [5:0] o,
                                          input logic [5:0] f,
                                          input logic z);
    logic io, mw, irw, rd, m2r, rw, sa, pe, ok;
    logic [1:0] sb, ps;
    logic [3:0] alu;
    {io, mw, irw, rd, m2r, rw, sa, pe, ok} = '0;
    sb = 2'b00;
    ps = 2'b00;
    alu = 4'b0000;
    case (s)
      4'd0: begin sb = 2'b01; irw = 1'b1; pe = 1'b1; end
      4'd1: sb = 2'b11;
      4'd2, 4'd9: begin sa = 1'b1; sb = 2'b10; end
      4'd3: io = 1'b1;
      4'd4: begin m2r = 1'b1; rw = 1'b1; end
      4'd5: begin io = 1'b1; mw = 1'b1; end
      4'd6: begin sa = 1'b1; alu = funct_alu(f, ok); end
      4'd7: begin rd = 1'b1; rw = 1'b1; end
      4'd8: begin
        sa = 1'b1;
        alu = 4'b0010;
        ps = 2'b01;
        pe = z;
`ifdef MIPS_CTRL_BNE_EN
        if (o == 6'b000101) pe = ~z;
`endif
      end
      4'd10: rw = 1'b1;
      4'd11: begin ps = 2'b10; pe = 1'b1; end
      default: ;
    endcase
    return {s, io, mw, irw, rd, m2r, rw, sa, sb, ps, pe, alu};
  endfunction

  logic [3:0]  exp_state = 4'd0;
  logic [31:0] pv = '0;
  int          plen = 0;
  int          pidx = 0;
  logic        mvalid = 1'b0;

  always @(posedge clk) begin
    int n;
    logic [31:0] p;
    if (reset) begin
      exp_state <= 4'd0;
      pidx <= 0;
      plen <= 0;
      mvalid <= 1'b1;
    end else if (mvalid) begin
      if (exp_state == 4'd0) begin
        p = path_of(op, funct, n);
        pv <= p;
        plen <= n;
        pidx <= 1;
        exp_state <= p[3:0];
      end else if (pidx >= plen) begin
        exp_state <= 4'd0;
      end else begin
        exp_state <= pv[pidx*4 +: 4];
        pidx <= pidx + 1;
      end
    end
  end

  logic        lit_en = 1'b0;
  string       lit_name = "";
  logic [31:0] lit_got = '0;
  logic [31:0] lit_want = '0;

  always @(negedge clk) begin
    logic [19:0] e, a;
    if (mvalid) begin
      e = exp_vec(exp_state, op, funct, zero);
      a = {state, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, pcen, aluop};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle_outputs t=%0t op=%b got %h want %h",
                 $time, op, a, e);
      end
    end
    if (lit_en) begin
      checks++;
      if (lit_got !== lit_want) begin
        errors++;
        $display("FAIL %s got %0h want %0h", lit_name, lit_got, lit_want);
      end
    end
  end

  task automatic lit(input string nm, input logic [31:0] g,
                     input logic [31:0] w);
    lit_name = nm;
    lit_got = g;
    lit_want = w;
    lit_en = 1'b1;
    @(negedge clk);
    #1 lit_en = 1'b0;
  endtask

  task automatic run_instr(input string nm, input logic [5:0] o,
                           input logic [5:0] f, input logic z,
                           input int want_len);
    int n;
    logic [31:0] hist;
    op = o;
    funct = f;
    zero = z;
    n = 0;
    hist = '0;
    do begin
      @(posedge clk);
      #1;
      n++;
      hist = {hist[27:0], state};
    end while (state != 4'd0 && n < 12);
    if (nm == "lw_seq") lit(nm, hist, 32'h0001_2340);
    else lit(nm, n, want_len);
  endtask

  initial begin
    reset = 1'b1;
    op = 6'b0;
    funct = 6'b0;
    zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    lit("reset_state", {28'h0, state}, 32'h0);
    reset = 1'b0;

    run_instr("lw_seq", 6'b100011, 6'b0, 1'b0, 5);
    run_instr("lw_len", 6'b100011, 6'b0, 1'b1, 5);
    run_instr("sw_len", 6'b101011, 6'b0, 1'b0, 4);
    run_instr("slt_len", 6'b000000, 6'b101010, 1'b0, 4);
    run_instr("add_len", 6'b000000, 6'b100000, 1'b0, 4);
    run_instr("sub_len", 6'b000000, 6'b100010, 1'b1, 4);
    run_instr("and_len", 6'b000000, 6'b100100, 1'b0, 4);
    run_instr("or_len", 6'b000000, 6'b100101, 1'b0, 4);
    run_instr("xor_len", 6'b000000, 6'b100110, 1'b0, 4);
    run_instr("nor_len", 6'b000000, 6'b100111, 1'b0, 4);
    run_instr("rbad_len", 6'b000000, 6'b000001, 1'b0, 3);
    run_instr("addi_len", 6'b001000, 6'b0, 1'b0, 4);
    run_instr("beq_taken", 6'b000100, 6'b0, 1'b1, 3);
    run_instr("beq_not", 6'b000100, 6'b0, 1'b0, 3);
    run_instr("j_len", 6'b000010, 6'b0, 1'b0, 3);
    run_instr("illegal_len", 6'b111111, 6'b0, 1'b0, 2);
`ifdef MIPS_CTRL_BNE_EN
    run_instr("bne_not_zero", 6'b000101, 6'b0, 1'b0, 3);
    run_instr("bne_zero", 6'b000101, 6'b0, 1'b1, 3);
`else
    run_instr("bne_off_len", 6'b000101, 6'b0, 1'b0, 2);
`endif

    op = 6'b101011;
    funct = 6'b0;
    zero = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    lit("memwr_state", {27'h0, state, memwrite}, {27'h0, 4'd5, 1'b1});
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    lit("reset_abort", {26'h0, state, memwrite, regwrite},
        {26'h0, 4'd0, 2'b00});
    run_instr("lw_after_rst", 6'b100011, 6'b0, 1'b0, 5);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
